// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : RAW hazard stall/flush control and EX operand-forward selects for
//            a 5-stage RISC-V style pipeline. Define PIPE_FORWARD_EN to build
//            with forwarding (load-use stall only); otherwise stall on any RAW.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int INST_W      = 32,
    parameter int RA_W        = 5,
    parameter int TRACK_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] inst_id,
    input  logic              id_valid,
    input  logic              br_taken_ex,
    output logic              pc_we,
    output logic              flush_ifid,
    output logic              ex_valid,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_we_reg,
    output logic              ex_is_load,
    output logic              ex_we_dram,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [1:0] c_TD        = 2'(TRACK_DEPTH);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            we_reg;
        logic            is_load;
        logic            we_dram;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
    } stage_t;

    // Index 0 = EX, 1 = MEM, 2 = WB
    stage_t          st_q [3];
    stage_t          st_d [3];
    stage_t          w_dec;
    logic [6:0]      w_opcode;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_hazard;
    logic            w_unused;

    function automatic logic raw_match(input stage_t s, input logic [RA_W-1:0] rs1,
                                       input logic u1, input logic [RA_W-1:0] rs2,
                                       input logic u2);
        raw_match = s.valid && s.we_reg &&
                    ((u1 && (rs1 != '0) && (rs1 == s.rd)) ||
                     (u2 && (rs2 != '0) && (rs2 == s.rd)));
    endfunction

    assign w_opcode   = inst_id[6:0];
    assign w_rs1_used = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) ||
                          (w_opcode == c_OP_JAL));
    assign w_rs2_used = (w_opcode == c_OP_REG) || (w_opcode == c_OP_STORE) ||
                        (w_opcode == c_OP_BRANCH);

    always_comb begin
        w_dec         = '0;
        w_dec.valid   = id_valid;
        w_dec.rd      = inst_id[7 +: RA_W];
        w_dec.rs1     = inst_id[15 +: RA_W];
        w_dec.rs2     = inst_id[20 +: RA_W];
        w_dec.is_load = (w_opcode == c_OP_LOAD);
        w_dec.we_dram = (w_opcode == c_OP_STORE);
        w_dec.we_reg  = !((w_opcode == c_OP_STORE) || (w_opcode == c_OP_BRANCH)) &&
                        (inst_id[7 +: RA_W] != '0);
    end

`ifdef PIPE_FORWARD_EN
    // Only a load in EX cannot be forwarded in time: one-cycle load-use stall
    assign w_hazard = id_valid && st_q[0].is_load &&
                      raw_match(st_q[0], w_dec.rs1, w_rs1_used, w_dec.rs2, w_rs2_used);

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (st_q[1].valid && st_q[1].we_reg && (st_q[1].rd != '0) && (st_q[1].rd == st_q[0].rs1))
            fwd_a_sel = 2'b01;
        else if (st_q[2].valid && st_q[2].we_reg && (st_q[2].rd != '0) && (st_q[2].rd == st_q[0].rs1))
            fwd_a_sel = 2'b10;
        if (st_q[1].valid && st_q[1].we_reg && (st_q[1].rd != '0) && (st_q[1].rd == st_q[0].rs2))
            fwd_b_sel = 2'b01;
        else if (st_q[2].valid && st_q[2].we_reg && (st_q[2].rd != '0) && (st_q[2].rd == st_q[0].rs2))
            fwd_b_sel = 2'b10;
    end
`else
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            if (raw_match(st_q[k], w_dec.rs1, w_rs1_used, w_dec.rs2, w_rs2_used))
                w_hazard = 1'b1;
        end
        w_hazard = w_hazard && id_valid;
    end

    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // A redirect outranks a stall: the stalled instruction is on the wrong path
    assign pc_we      = !rst_n || br_taken_ex || !w_hazard;
    assign flush_ifid = rst_n && br_taken_ex;

    always_comb begin
        st_d[0] = (br_taken_ex || w_hazard) ? stage_t'('0) : w_dec;
        st_d[1] = st_q[0];
        st_d[2] = st_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) st_q[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) st_q[k] <= st_d[k];
        end
    end

    assign ex_valid   = st_q[0].valid;
    assign ex_rd      = st_q[0].rd;
    assign ex_we_reg  = st_q[0].we_reg;
    assign ex_is_load = st_q[0].is_load;
    assign ex_we_dram = st_q[0].we_dram;

    assign w_unused = ^{inst_id, st_q[0], st_q[1], st_q[2], c_TD};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Randomized scoreboard bench for pipe_hazard_ctrl against a
//            history-queue reference model of the hazard rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int TD = 2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_id;
    logic        id_valid;
    logic        br_taken_ex;
    logic        pc_we, flush_ifid, ex_valid, ex_we_reg, ex_is_load, ex_we_dram;
    logic [4:0]  ex_rd;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    pipe_hazard_ctrl #(.INST_W(32), .RA_W(5), .TRACK_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .id_valid(id_valid),
        .br_taken_ex(br_taken_ex), .pc_we(pc_we), .flush_ifid(flush_ifid),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we_reg(ex_we_reg),
        .ex_is_load(ex_is_load), .ex_we_dram(ex_we_dram),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       we, ld, wd;
        logic [4:0] rs1, rs2;
    } rec_t;

    typedef struct {
        logic       exv;
        logic [4:0] rd;
        logic       we, ld, wd, pc, fl;
        logic [1:0] fa, fb;
    } exp_t;

    rec_t hist[$];      // instructions in EX, MEM, WB order (front = EX)
    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    logic last_pc;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, x, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        logic [6:0] top = 7'($urandom);
        logic [2:0] f3  = 3'($urandom);
        return {top, rs2, rs1, f3, rd, op};
    endfunction

    function automatic rec_t bubble();
        rec_t r;
        r.v = 0; r.rd = 0; r.we = 0; r.ld = 0; r.wd = 0; r.rs1 = 0; r.rs2 = 0;
        return r;
    endfunction

    function automatic rec_t decode(input logic [31:0] ins, input logic v);
        rec_t r;
        logic [6:0] op = ins[6:0];
        r.v   = v;
        r.rd  = ins[11:7];
        r.rs1 = ins[19:15];
        r.rs2 = ins[24:20];
        r.ld  = (op == OP_LOAD);
        r.wd  = (op == OP_STORE);
        r.we  = (op != OP_STORE) && (op != OP_BRANCH) && (r.rd != 0);
        return r;
    endfunction

    // Does instruction ins read architectural register x (x0 never counts)?
    function automatic bit reads(input logic [31:0] ins, input logic [4:0] x);
        logic [6:0] op = ins[6:0];
        bit u1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        bit u2 = (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
        if (x == 0) return 0;
        return (u1 && ins[19:15] == x) || (u2 && ins[24:20] == x);
    endfunction

    function automatic bit hazard(input logic [31:0] ins, input logic v);
        if (!v) return 0;
`ifdef PIPE_FORWARD_EN
        return hist[0].v && hist[0].we && hist[0].ld && reads(ins, hist[0].rd);
`else
        for (int k = 0; k < TD; k++)
            if (hist[k].v && hist[k].we && reads(ins, hist[k].rd)) return 1;
        return 0;
`endif
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
`ifdef PIPE_FORWARD_EN
        if (hist[1].v && hist[1].we && hist[1].rd != 0 && hist[1].rd == src) return 2'b01;
        if (hist[2].v && hist[2].we && hist[2].rd != 0 && hist[2].rd == src) return 2'b10;
`endif
        return {1'b0, src[0] & 1'b0};
    endfunction

    function automatic void clear_hist();
        hist.delete();
        repeat (3) hist.push_back(bubble());
    endfunction

    // One clock of stimulus; the expected outputs for this cycle go to the scoreboard
    task automatic issue(input logic [31:0] ins, input logic v, input logic br, input logic rn);
        exp_t e;
        bit   hz;
        @(posedge clk); #1;
        rst_n = rn; inst_id = ins; id_valid = v; br_taken_ex = br;
        if (!rn) clear_hist();
        hz    = rn && hazard(ins, v);
        e.exv = hist[0].v;  e.rd = hist[0].rd; e.we = hist[0].we;
        e.ld  = hist[0].ld; e.wd = hist[0].wd;
        e.pc  = !rn || br || !hz;
        e.fl  = rn && br;
        e.fa  = fsel(hist[0].rs1);
        e.fb  = fsel(hist[0].rs2);
        expq.push_back(e);
        last_pc = e.pc;
        if (rn) begin
            void'(hist.pop_back());
            hist.push_front((br || hz) ? bubble() : decode(ins, v));
        end
    endtask

    // Present an instruction and hold it in ID for as long as the model stalls
    task automatic send(input logic [31:0] ins, input logic v, input logic br);
        issue(ins, v, br, 1'b1);
        for (int i = 0; i < 6 && !last_pc; i++) issue(ins, v, 1'b0, 1'b1);
    endtask

    task automatic drain();
        repeat (3) send(mk(OP_IMM, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(e.exv));
                if (e.exv) begin
                    chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                    chk("ex_we_reg", 32'(ex_we_reg), 32'(e.we));
                    chk("ex_is_load", 32'(ex_is_load), 32'(e.ld));
                    chk("ex_we_dram", 32'(ex_we_dram), 32'(e.wd));
                end
                chk("pc_we", 32'(pc_we), 32'(e.pc));
                chk("flush_ifid", 32'(flush_ifid), 32'(e.fl));
                chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e.fa));
                chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e.fb));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [6:0] ops [9] = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_REG, OP_IMM,
                                OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
        logic [31:0] ins;
        rst_n = 1'b0; inst_id = '0; id_valid = 1'b0; br_taken_ex = 1'b0;
        clear_hist();
        last_pc = 1'b1;
        repeat (3) issue(32'h0, 1'b0, 1'b1, 1'b0);

`ifdef PIPE_FORWARD_EN
        // load-use: one stall, then WB forward to rs1
        send(mk(OP_LOAD, 5'd5, 5'd1, 5'd0), 1'b1, 1'b0);
        send(mk(OP_REG, 5'd6, 5'd5, 5'd1), 1'b1, 1'b0);
        drain();
        // ALU result forwarded from MEM to both operands, no stall
        send(mk(OP_IMM, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0);
        send(mk(OP_REG, 5'd4, 5'd3, 5'd3), 1'b1, 1'b0);
        drain();
`else
        // no forwarding: dependent add waits out the producer's EX and MEM
        send(mk(OP_IMM, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0);
        send(mk(OP_REG, 5'd4, 5'd3, 5'd0), 1'b1, 1'b0);
        drain();
`endif
        // hazard coinciding with a taken branch
        send(mk(OP_LOAD, 5'd3, 5'd0, 5'd0), 1'b1, 1'b0);
        send(mk(OP_REG, 5'd4, 5'd3, 5'd0), 1'b1, 1'b1);
        drain();
        // x0 writer then x0 reader
        send(mk(OP_IMM, 5'd0, 5'd1, 5'd0), 1'b1, 1'b0);
        send(mk(OP_REG, 5'd7, 5'd0, 5'd0), 1'b1, 1'b0);
        drain();
        // reset pulse in the middle of a stall
        send(mk(OP_LOAD, 5'd2, 5'd1, 5'd0), 1'b1, 1'b0);
        ins = mk(OP_REG, 5'd8, 5'd2, 5'd2);
        issue(ins, 1'b1, 1'b0, 1'b1);
        issue(ins, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_ex_we_reg", 32'(ex_we_reg), 32'd0);
        chk("rst_ex_is_load", 32'(ex_is_load), 32'd0);
        chk("rst_ex_we_dram", 32'(ex_we_dram), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd1);
        send(ins, 1'b1, 1'b0);
        drain();

        for (int n = 0; n < 400; n++) begin
            ins = mk(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 59) == 0)
                issue(ins, 1'b1, 1'b0, 1'b0);
            send(ins, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter INST_W, default 32: instruction width; opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
REQ-002 SHALL have parameter RA_W, default 5: register-address width.
REQ-003 SHALL have parameter TRACK_DEPTH, default 2, legal 1..3: number of post-ID stages (EX, MEM, WB order) checked for RAW hazards when forwarding is absent.
REQ-004 SHALL have port clk  input  1: sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port inst_id  input  INST_W: instruction in ID.
REQ-007 SHALL have port id_valid  input  1: inst_id holds a real instruction.
REQ-008 SHALL have port br_taken_ex  input  1: branch/jal/jalr in EX is redirecting the PC this cycle.
REQ-009 SHALL have port pc_we  output  1: PC and IF/ID register update enable.
REQ-010 SHALL have port flush_ifid  output  1: IF/ID register loads a bubble.
REQ-011 SHALL have port ex_valid, ex_rd[RA_W], ex_we_reg, ex_is_load, ex_we_dram  output: registered ID/EX control bundle.
REQ-012 SHALL have port fwd_a_sel, fwd_b_sel  output  2 each: EX operand source; 00 regfile, 01 MEM result, 10 WB result.

Function
REQ-013 SHALL decode from inst_id: is_load = opcode 0000011; we_dram = opcode 0100011; we_reg = 0 for opcodes 0100011 and 1100011, 0 when rd = 0, else 1.
REQ-014 SHALL treat rs1 as used for every opcode except 0110111, 0010111 and 1101111, and rs2 as used only for 0110011, 0100011 and 1100011.
REQ-015 SHALL keep the tracking stages EX, MEM, WB, each holding {valid, rd, we_reg, is_load, rs1, rs2}; each rising edge shifts EX->MEM->WB, and WB is discarded.
REQ-016 SHALL raise hazard when id_valid, a used rs of ID is non-zero, and it equals rd of a valid, we_reg tracked stage within the compare window.
REQ-017 SHALL, with forwarding compiled in, use a compare window of the EX stage only, and only when EX is_load = 1 (load-use).
REQ-018 SHALL, with forwarding compiled out, use a compare window of stages 1..TRACK_DEPTH regardless of is_load.
REQ-019 SHALL, on hazard without br_taken_ex, drive pc_we = 0, hold IF/ID, and load EX with a bubble (valid = 0) at the next edge.
REQ-020 SHALL, on br_taken_ex = 1, drive flush_ifid = 1 and pc_we = 1, and load EX with a bubble at the next edge; flush wins over hazard in the same cycle.
REQ-021 SHALL, with no hazard and no flush, drive pc_we = 1 and flush_ifid = 0, and load EX from the ID decode with valid = id_valid.
REQ-022 SHALL derive fwd_a_sel and fwd_b_sel combinationally from EX rs1/rs2 against MEM, then WB (valid, we_reg, rd != 0); a MEM match takes priority over a WB match.
REQ-023 SHALL hold EX stall latency at exactly 1 cycle for a load-use hazard with forwarding, and at most TRACK_DEPTH cycles without forwarding.
REQ-024 SHALL keep ex_* outputs registered, and pc_we and flush_ifid combinational from the current state and inputs.

Reset
REQ-025 SHALL, while rst_n = 0, clear all tracking stages (valid = 0, fields 0) asynchronously.
REQ-026 SHALL hold these values in reset: ex_valid = 0, ex_rd = 0, ex_we_reg = 0, ex_is_load = 0, ex_we_dram = 0, fwd_*_sel = 00, pc_we = 1, flush_ifid = 0.
REQ-027 SHALL, on reset asserted mid-stall, abandon the stall, and the first edge after release SHALL accept ID normally.

Configuration
REQ-028 SHALL compile in forwarding detection (REQ-017 window, REQ-022 selects) when macro PIPE_FORWARD_EN is defined.
REQ-029 SHALL, when PIPE_FORWARD_EN is undefined, tie fwd_a_sel and fwd_b_sel to 00 and apply the REQ-018 window.

Verification
REQ-030 SHALL cover: with PIPE_FORWARD_EN, lw x5 then add x6,x5,x1 -> one cycle of pc_we = 0 and an EX bubble, then fwd_a_sel = 10 when add reaches EX.
REQ-031 SHALL cover: with PIPE_FORWARD_EN, addi x3 then sub x4,x3,x3 -> no stall, fwd_a_sel = fwd_b_sel = 01.
REQ-032 SHALL cover: without PIPE_FORWARD_EN and TRACK_DEPTH = 2, addi x3 then add x4,x3,x0 -> pc_we = 0 for 2 cycles, then add enters EX.
REQ-033 SHALL cover: hazard and br_taken_ex asserted in the same cycle -> flush_ifid = 1, pc_we = 1, ex_valid = 0 next cycle.
REQ-034 SHALL cover: write to x0 followed by a reader of x0 -> no stall, fwd selects = 00.
REQ-035 SHALL cover: rst_n pulsed low during a stall -> all ex_* outputs 0 immediately, pc_we = 1, normal flow after release.
